// File: rtl/uart_mmio_sequencer_if.sv
`timescale 1ns/1ps
// MMIO bus between the UART sequencer (master) and the UART register block
// (slave). Read data is combinational and sampled in the strobe cycle.
interface uart_mmio_sequencer_if;
    logic [31:0] data_address;
    logic [31:0] data_store;
    logic        data_read;
    logic        data_enable;
    logic [31:0] data_fetch;

    modport master (
        output data_address,
        output data_store,
        output data_read,
        output data_enable,
        input  data_fetch
    );

    modport slave (
        input  data_address,
        input  data_store,
        input  data_read,
        input  data_enable,
        output data_fetch
    );
endinterface

// File: rtl/uart_mmio_sequencer.sv
`timescale 1ns/1ps
// UART MMIO sequencer: owns the UART register port, programs the baud
// divisor, polls status and moves bytes between the UART and two small
// FIFOs facing a byte-stream client.
// Optional macro UART_SEQ_RX_DROP_EN: when the RX FIFO is full, pending UART
// bytes are still read and discarded, counted in rx_drop_cnt.
module uart_mmio_sequencer #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_set,
    input  logic [31:0] baud_div,
    output logic        cfg_done,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
`ifdef UART_SEQ_RX_DROP_EN
    output logic [15:0] rx_drop_cnt,
`endif
    uart_mmio_sequencer_if.master mmio
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [31:0] ADDR_BAUD   = 32'h0;
    localparam logic [31:0] ADDR_GETC   = 32'h4;
    localparam logic [31:0] ADDR_SETC   = 32'h8;
    localparam logic [31:0] ADDR_STATUS = 32'hC;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_POLL, S_RDC, S_WRC, S_HOLD} state_t;

    state_t state, state_next;

    logic              pend_flag;
    logic [31:0]       pend_val;
    logic              tx_busy, busy_next;
    logic              rr, rr_next;
    logic              cfg_wr;

    logic [7:0]        tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr, tx_rd;
    logic [TX_CW-1:0]  tx_cnt;
    logic              tx_full, tx_empty, tx_push, tx_pop;

    logic [7:0]        rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr, rx_rd;
    logic [RX_CW-1:0]  rx_cnt;
    logic              rx_full, rx_empty, rx_push, rx_pop;

    logic              rx_elig, tx_elig;
`ifdef UART_SEQ_RX_DROP_EN
    logic              rx_drop;
`endif

    assign tx_full  = (tx_cnt == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    assign rx_full  = (rx_cnt == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_mem[rx_rd];
    assign rx_pop   = rx_ready && !rx_empty;

    // State register; reset parks in IDLE with a baud write pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state, MMIO access decode and FIFO/flag side effects.
    always_comb begin
        state_next        = state;
        mmio.data_address = 32'h0;
        mmio.data_store   = 32'h0;
        mmio.data_read    = 1'b0;
        mmio.data_enable  = 1'b0;
        tx_pop            = 1'b0;
        rx_push           = 1'b0;
        cfg_wr            = 1'b0;
        busy_next         = tx_busy;
        rr_next           = rr;
        rx_elig           = 1'b0;
        tx_elig           = 1'b0;
`ifdef UART_SEQ_RX_DROP_EN
        rx_drop           = 1'b0;
`endif
        case (state)
            S_IDLE: begin
`ifdef UART_SEQ_RX_DROP_EN
                // Keep polling while full so pending bytes can be discarded.
                if (pend_flag) state_next = S_CFG;
                else           state_next = S_POLL;
`else
                if (pend_flag)                   state_next = S_CFG;
                else if (!rx_full || !tx_empty)  state_next = S_POLL;
`endif
            end
            S_CFG: begin
                mmio.data_enable  = 1'b1;
                mmio.data_address = ADDR_BAUD;
                mmio.data_store   = pend_val;
                cfg_wr            = 1'b1;
                busy_next         = 1'b0;
                state_next        = S_IDLE;
            end
            S_POLL: begin
                mmio.data_enable  = 1'b1;
                mmio.data_read    = 1'b1;
                mmio.data_address = ADDR_STATUS;
                if (tx_busy && mmio.data_fetch[0]) busy_next = 1'b0;
`ifdef UART_SEQ_RX_DROP_EN
                rx_elig = mmio.data_fetch[1];
`else
                rx_elig = mmio.data_fetch[1] && !rx_full;
`endif
                tx_elig = !tx_empty && !busy_next;
                // rr=0 favours RX; the granted side hands priority over.
                if (rx_elig && (!tx_elig || !rr)) begin
                    state_next = S_RDC;
                    rr_next    = 1'b1;
                end else if (tx_elig) begin
                    state_next = S_WRC;
                    rr_next    = 1'b0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RDC: begin
                mmio.data_enable  = 1'b1;
                mmio.data_read    = 1'b1;
                mmio.data_address = ADDR_GETC;
                rx_push           = !rx_full;
`ifdef UART_SEQ_RX_DROP_EN
                rx_drop           = rx_full;
`endif
                state_next        = S_IDLE;
            end
            S_WRC: begin
                mmio.data_enable  = 1'b1;
                mmio.data_address = ADDR_SETC;
                mmio.data_store   = {24'h0, tx_mem[tx_rd]};
                tx_pop            = 1'b1;
                busy_next         = 1'b1;
                state_next        = S_HOLD;
            end
            S_HOLD: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Baud request capture (last one wins), config status, TX busy and arbiter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_flag <= 1'b1;
            pend_val  <= 32'(BAUD_DIV);
            cfg_done  <= 1'b0;
            tx_busy   <= 1'b0;
            rr        <= 1'b0;
        end else begin
            if (baud_set) begin
                pend_flag <= 1'b1;
                pend_val  <= baud_div;
            end else if (cfg_wr) begin
                pend_flag <= 1'b0;
            end
            if (cfg_wr) cfg_done <= 1'b1;
            tx_busy <= busy_next;
            rr      <= rr_next;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop both apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // FIFO storage; contents are meaningful only through the counts.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
        if (rx_push) rx_mem[rx_wr] <= mmio.data_fetch[7:0];
    end

`ifdef UART_SEQ_RX_DROP_EN
    // Saturating count of bytes discarded because the RX FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                rx_drop_cnt <= 16'h0;
        else if (rx_drop && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'h1;
    end
`endif
endmodule

// File: tb/tb_uart_mmio_sequencer.sv
`timescale 1ns/1ps
// Directed bench for uart_mmio_sequencer with a small UART register model.
module tb_uart_mmio_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_set = 1'b0;
    logic [31:0] baud_div = 32'h0;
    logic        cfg_done;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
`ifdef UART_SEQ_RX_DROP_EN
    logic [15:0] rx_drop_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    uart_mmio_sequencer_if mmio ();

    uart_mmio_sequencer #(.BAUD_DIV(434), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_set (baud_set),
        .baud_div (baud_div),
        .cfg_done (cfg_done),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
`ifdef UART_SEQ_RX_DROP_EN
        .rx_drop_cnt (rx_drop_cnt),
`endif
        .mmio     (mmio)
    );

    always #5 clk = ~clk;

    // UART model: tx_done rises tx_delay cycles after a setchar write,
    // rx_rdy is high while supplied bytes remain unread.
    int          cyc       = 0;
    int          last_wrc  = -100000;
    int          rx_taken  = 0;
    int          rx_supply = 0;
    int          rx_mark   = 0;
    int          tx_delay  = 0;
    logic [7:0]  rx_base   = 8'h0;
    logic        tx_done_bit, rx_rdy_bit;

    assign tx_done_bit = (cyc - last_wrc) >= tx_delay;
    assign rx_rdy_bit  = rx_supply > rx_taken;

    always_comb begin
        mmio.data_fetch = 32'h0;
        if (mmio.data_address == 32'hC)
            mmio.data_fetch = {30'h0, rx_rdy_bit, tx_done_bit};
        else if (mmio.data_address == 32'h4)
            mmio.data_fetch = {24'h0, rx_base + 8'(rx_taken - rx_mark)};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mmio.data_enable && !mmio.data_read && mmio.data_address == 32'h8) last_wrc <= cyc;
        if (mmio.data_enable && mmio.data_read && mmio.data_address == 32'h4) rx_taken <= rx_taken + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        int          cyc;
    } acc_t;
    acc_t acc_q[$];
    acc_t mon_a;

    always @(negedge clk) begin
        if (mmio.data_enable) begin
            mon_a.addr = mmio.data_address;
            mon_a.data = mmio.data_store;
            mon_a.rd   = mmio.data_read;
            mon_a.cyc  = cyc;
            acc_q.push_back(mon_a);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int c0;
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (mmio.data_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %0h want 0", mmio.data_enable); end
        n_vec++; if (mmio.data_address !== 32'h0) begin n_fail++; $display("FAIL rst_address: got %0h want 0", mmio.data_address); end
        n_vec++; if (mmio.data_store !== 32'h0) begin n_fail++; $display("FAIL rst_store: got %0h want 0", mmio.data_store); end
        n_vec++; if (mmio.data_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %0h want 0", mmio.data_read); end
        n_vec++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_done: got %0h want 0", cfg_done); end
        n_vec++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %0h want 1", tx_ready); end
        n_vec++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %0h want 0", rx_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        acc_q.delete();
        @(negedge clk);
        n_vec++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL cfg_done_early: got %0h want 0", cfg_done); end
        for (int i = 0; i < 10 && acc_q.size() == 0; i++) tick();
        n_vec++;
        if (acc_q.size() == 0) begin
            n_fail++; $display("FAIL first_access: got none want baud write");
        end else begin
            if (acc_q[0].cyc !== c0 + 1) begin n_fail++; $display("FAIL first_access_cycle: got %0d want %0d", acc_q[0].cyc, c0 + 1); end
            n_vec++; if (acc_q[0].addr !== 32'h0) begin n_fail++; $display("FAIL first_access_addr: got %0h want 0", acc_q[0].addr); end
            n_vec++; if (acc_q[0].data !== 32'd434) begin n_fail++; $display("FAIL first_access_data: got %0d want 434", acc_q[0].data); end
            n_vec++; if (acc_q[0].rd !== 1'b0) begin n_fail++; $display("FAIL first_access_rd: got %0h want 0", acc_q[0].rd); end
        end
        @(negedge clk);
        n_vec++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL cfg_done_set: got %0h want 1", cfg_done); end
    endtask

    task automatic test_tx();
        int w_idx[$];
        int w0, w1;
        tx_delay = 20;
        acc_q.delete();
        tick();
        tx_valid = 1'b1; tx_data = 8'h41;
        tick();
        tx_data = 8'h42;
        tick();
        tx_valid = 1'b0;
        repeat (45) tick();
        foreach (acc_q[i]) if (!acc_q[i].rd && acc_q[i].addr == 32'h8) w_idx.push_back(i);
        n_vec++; if (w_idx.size() != 2) begin n_fail++; $display("FAIL tx_write_count: got %0d want 2", w_idx.size()); end
        if (w_idx.size() == 2) begin
            w0 = w_idx[0]; w1 = w_idx[1];
            n_vec++; if (acc_q[w0].data !== 32'h41) begin n_fail++; $display("FAIL tx_first_byte: got %0h want 41", acc_q[w0].data); end
            n_vec++; if (acc_q[w1].data !== 32'h42) begin n_fail++; $display("FAIL tx_second_byte: got %0h want 42", acc_q[w1].data); end
            n_vec++;
            if (w0 == 0 || acc_q[w0 - 1].addr !== 32'hC || acc_q[w0 - 1].cyc !== acc_q[w0].cyc - 1) begin
                n_fail++; $display("FAIL tx_after_poll: got idx %0d want a poll one cycle before write", w0);
            end
            n_vec++;
            if (w0 + 1 >= acc_q.size() || acc_q[w0 + 1].cyc !== acc_q[w0].cyc + 3) begin
                n_fail++; $display("FAIL tx_hold_gap: got next access not at +3 want +3");
            end
            n_vec++; if (acc_q[w1].cyc - acc_q[w0].cyc !== 22) begin n_fail++; $display("FAIL tx_done_wait: got %0d want 22", acc_q[w1].cyc - acc_q[w0].cyc); end
        end
        tx_delay = 0;
    endtask

    task automatic test_alternate();
        acc_t np[$];
        acc_q.delete();
        rx_ready = 1'b1;
        rx_mark = rx_taken;
        rx_base = 8'h30;
        tick();
        rx_supply = rx_taken + 4;
        tx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tx_data = 8'h10 + 8'(k);
            tick();
        end
        tx_valid = 1'b0;
        repeat (50) tick();
        foreach (acc_q[i]) if (acc_q[i].addr != 32'hC) np.push_back(acc_q[i]);
        n_vec++; if (np.size() != 8) begin n_fail++; $display("FAIL alt_count: got %0d want 8", np.size()); end
        for (int k = 0; k < 8 && k < np.size(); k++) begin
            n_vec++;
            if (np[k].addr !== ((k % 2 == 0) ? 32'h4 : 32'h8)) begin
                n_fail++; $display("FAIL alt_order[%0d]: got %0h want %0h", k, np[k].addr, (k % 2 == 0) ? 32'h4 : 32'h8);
            end
            if (k % 2 == 1) begin
                n_vec++;
                if (np[k].data !== 32'h10 + 32'(k / 2)) begin
                    n_fail++; $display("FAIL alt_txbyte[%0d]: got %0h want %0h", k, np[k].data, 32'h10 + 32'(k / 2));
                end
            end
        end
        n_vec++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL alt_rx_drained: got %0h want 0", rx_valid); end
        n_vec++; if (rx_taken !== rx_supply) begin n_fail++; $display("FAIL alt_uart_drained: got %0d want %0d", rx_taken, rx_supply); end
        rx_ready = 1'b0;
    endtask

    task automatic test_rx();
        logic found;
        int   n_rd;
        acc_t a;
        acc_q.delete();
        rx_ready = 1'b0;
        rx_mark = rx_taken;
        rx_base = 8'h5A;
        tick();
        rx_supply = rx_taken + 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            foreach (acc_q[j]) if (!found && acc_q[j].addr != 32'hC) begin found = 1'b1; a = acc_q[j]; end
        end
        n_vec++;
        if (!found) begin
            n_fail++; $display("FAIL rx_read_timeout: got no getchar read want one");
        end else begin
            if (a.addr !== 32'h4 || a.rd !== 1'b1) begin n_fail++; $display("FAIL rx_read_access: got addr %0h rd %0h want 4 1", a.addr, a.rd); end
        end
        @(negedge clk);
        n_vec++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid_set: got %0h want 1", rx_valid); end
        n_vec++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rx_data: got %0h want 5a", rx_data); end
        repeat (3) tick();
        n_vec++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid_hold: got %0h want 1", rx_valid); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_pop: got %0h want 0", rx_valid); end
        n_rd = 0;
        foreach (acc_q[j]) if (acc_q[j].addr == 32'h4) n_rd++;
        n_vec++; if (n_rd !== 1) begin n_fail++; $display("FAIL rx_read_count: got %0d want 1", n_rd); end
    endtask

    task automatic test_rx_full();
        int n_rd;
        acc_q.delete();
        rx_ready = 1'b0;
        rx_mark = rx_taken;
        rx_base = 8'h60;
        tick();
        rx_supply = rx_taken + 9;
        repeat (60) tick();
        n_rd = 0;
        foreach (acc_q[j]) if (acc_q[j].addr == 32'h4) n_rd++;
`ifdef UART_SEQ_RX_DROP_EN
        n_vec++; if (n_rd !== 9) begin n_fail++; $display("FAIL full_read_count: got %0d want 9", n_rd); end
        n_vec++; if (rx_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL full_drop_cnt: got %0d want 1", rx_drop_cnt); end
`else
        n_vec++; if (n_rd !== 8) begin n_fail++; $display("FAIL full_read_count: got %0d want 8", n_rd); end
        n_vec++; if (rx_supply - rx_taken !== 1) begin n_fail++; $display("FAIL full_backpressure: got %0d want 1", rx_supply - rx_taken); end
`endif
        n_vec++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL full_rx_valid: got %0h want 1", rx_valid); end
        rx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h60 + 8'(k)) begin
                n_fail++; $display("FAIL full_drain[%0d]: got %0h want %0h", k, rx_data, 8'h60 + 8'(k));
            end
            tick();
        end
        rx_ready = 1'b0;
        repeat (10) tick();
`ifdef UART_SEQ_RX_DROP_EN
        n_vec++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL full_after_drop: got %0h want 0", rx_valid); end
`else
        n_vec++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h68) begin
            n_fail++; $display("FAIL full_ninth_byte: got valid %0h data %0h want 1 68", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
`endif
    endtask

    task automatic test_baud();
        logic found;
        int   wc, wi;
        acc_q.delete();
        tick();
        tx_valid = 1'b1; tx_data = 8'h77;
        tick();
        tx_valid = 1'b0;
        found = 1'b0;
        wc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mmio.data_enable && !mmio.data_read && mmio.data_address == 32'h8) found = 1'b1;
            else tick();
        end
        n_vec++;
        if (!found) begin
            n_fail++; $display("FAIL baud_wrc_timeout: got no setchar write want one");
        end else begin
            wc = cyc;
            baud_set = 1'b1; baud_div = 32'd868;
            tick();
            baud_set = 1'b0;
        end
        repeat (10) tick();
        wi = -1;
        foreach (acc_q[j]) if (acc_q[j].addr == 32'h8 && acc_q[j].cyc == wc) wi = j;
        n_vec++;
        if (wi < 0 || wi + 1 >= acc_q.size()) begin
            n_fail++; $display("FAIL baud_sequence: got write idx %0d want write then baud", wi);
        end else begin
            if (acc_q[wi].data !== 32'h77) begin n_fail++; $display("FAIL baud_wrc_data: got %0h want 77", acc_q[wi].data); end
            n_vec++; if (acc_q[wi + 1].addr !== 32'h0) begin n_fail++; $display("FAIL baud_addr: got %0h want 0", acc_q[wi + 1].addr); end
            n_vec++; if (acc_q[wi + 1].data !== 32'd868) begin n_fail++; $display("FAIL baud_data: got %0d want 868", acc_q[wi + 1].data); end
            n_vec++; if (acc_q[wi + 1].cyc !== wc + 3) begin n_fail++; $display("FAIL baud_cycle: got %0d want %0d", acc_q[wi + 1].cyc, wc + 3); end
        end
        n_vec++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL baud_cfg_done: got %0h want 1", cfg_done); end
    endtask

    task automatic test_last_wins();
        int n_cfg;
        logic [31:0] val;
        acc_q.delete();
        tick();
        baud_set = 1'b1; baud_div = 32'd1000;
        tick();
        baud_div = 32'd1234;
        tick();
        baud_set = 1'b0;
        repeat (10) tick();
        n_cfg = 0;
        val = 32'h0;
        foreach (acc_q[j]) if (acc_q[j].addr == 32'h0 && !acc_q[j].rd) begin n_cfg++; val = acc_q[j].data; end
        n_vec++; if (n_cfg !== 1) begin n_fail++; $display("FAIL last_wins_count: got %0d want 1", n_cfg); end
        n_vec++; if (val !== 32'd1234) begin n_fail++; $display("FAIL last_wins_value: got %0d want 1234", val); end
    endtask

    task automatic test_reset_mid();
        logic found;
        int   c0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mmio.data_enable) found = 1'b1;
        end
        n_vec++; if (!found) begin n_fail++; $display("FAIL mid_no_access: got none want an access"); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (mmio.data_enable !== 1'b0) begin n_fail++; $display("FAIL mid_enable: got %0h want 0", mmio.data_enable); end
        n_vec++; if (mmio.data_address !== 32'h0) begin n_fail++; $display("FAIL mid_address: got %0h want 0", mmio.data_address); end
        n_vec++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL mid_cfg_done: got %0h want 0", cfg_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        acc_q.delete();
        repeat (4) tick();
        n_vec++;
        if (acc_q.size() == 0) begin
            n_fail++; $display("FAIL mid_restart: got no access want baud write");
        end else begin
            if (acc_q[0].cyc !== c0 + 1 || acc_q[0].addr !== 32'h0) begin
                n_fail++; $display("FAIL mid_restart: got addr %0h cyc %0d want 0 %0d", acc_q[0].addr, acc_q[0].cyc, c0 + 1);
            end
            n_vec++; if (acc_q[0].data !== 32'd434) begin n_fail++; $display("FAIL mid_restart_data: got %0d want 434", acc_q[0].data); end
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_alternate();
        test_rx();
        test_rx_full();
        test_baud();
        test_last_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
